// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the UART boot loader: receive FSM states,
// error codes and the default frame start byte.
package boot_loader_pkg;

    typedef enum logic [3:0] {
        HUNT,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHK,
        DRAIN,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_CHECKSUM = 2'b01,
        ERR_OVERRUN  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/boot_timeout_counter.sv
// Inter-byte watchdog: counts enabled idle cycles since the last clear and
// flags the cycle in which the count reaches TIMEOUT_CYCLES.
module boot_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && count_q != MAX_COUNT) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Asserted combinationally so the abort lands on the edge that completes the budget.
    assign expired = enable && !clear && (count_q >= LAST_IDLE);

endmodule

// File: rtl/uart_boot_loader.sv
// Frames the UART byte stream, writes big-endian payload words to memory from
// LOAD_BASE and releases the CPU once the frame checksum verifies.
module uart_boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE      = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_wr_req,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic        mem_wr_ack,
    output logic        boot_done,
    output logic        boot_err,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    state_t      state_q, state_d;
    err_t        err_q, err_val;
    logic        err_set;

    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [7:0]  byte_hi_q;
    logic [7:0]  sum_q;
    logic [15:0] word_idx_q;
    logic [15:0] words_q;
    logic        chk_ok_q;

    logic        req_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;

    logic        ack_fire;
    logic        magic_hit;
    logic        word_done;
    logic        overrun;
    logic        last_word;
    logic        timer_en;
    logic        timeout;

    assign ack_fire  = req_q && mem_wr_ack;
    assign magic_hit = (state_q == HUNT) && rx_valid && (rx_data == MAGIC);
    assign word_done = (state_q == DATA_LO) && rx_valid;
    // An ack in the same cycle frees the holding register, so that is not an overrun.
    assign overrun   = word_done && req_q && !mem_wr_ack;
    assign last_word = (word_idx_q + 16'd1) == len_q;
    assign timer_en  = !(state_q inside {HUNT, DONE, ERROR});

    boot_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_valid || !timer_en),
        .enable (timer_en),
        .expired(timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        err_val = ERR_NONE;
        unique case (state_q)
            HUNT:    if (magic_hit) state_d = LEN_HI;
            LEN_HI:  if (rx_valid) state_d = LEN_LO;
            LEN_LO:  if (rx_valid) state_d = ({len_hi_q, rx_data} == 16'd0) ? CHK : DATA_HI;
            DATA_HI: if (rx_valid) state_d = DATA_LO;
            DATA_LO: begin
                if (overrun) begin
                    state_d = ERROR;
                    err_set = 1'b1;
                    err_val = ERR_OVERRUN;
                end else if (rx_valid) begin
                    state_d = last_word ? CHK : DATA_HI;
                end
            end
            CHK:     if (rx_valid) state_d = DRAIN;
            DRAIN: begin
                if (!req_q) begin
                    if (chk_ok_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                        err_set = 1'b1;
                        err_val = ERR_CHECKSUM;
                    end
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = HUNT;
            default: state_d = HUNT;
        endcase
        if (timeout) begin
            state_d = ERROR;
            err_set = 1'b1;
            err_val = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_hi_q   <= '0;
            len_q      <= '0;
            byte_hi_q  <= '0;
            sum_q      <= '0;
            word_idx_q <= '0;
            words_q    <= '0;
            chk_ok_q   <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            if (magic_hit) begin
                sum_q      <= '0;
                word_idx_q <= '0;
                words_q    <= '0;
                chk_ok_q   <= 1'b0;
                err_q      <= ERR_NONE;
            end else begin
                if (rx_valid) begin
                    unique case (state_q)
                        LEN_HI:  len_hi_q <= rx_data;
                        LEN_LO:  len_q    <= {len_hi_q, rx_data};
                        DATA_HI: begin
                            byte_hi_q <= rx_data;
                            sum_q     <= sum_q + rx_data;
                        end
                        DATA_LO: begin
                            sum_q      <= sum_q + rx_data;
                            word_idx_q <= word_idx_q + 16'd1;
                        end
                        CHK:     chk_ok_q <= (rx_data == sum_q);
                        default: ;
                    endcase
                end
                if (ack_fire) words_q <= words_q + 16'd1;
                if (err_set)  err_q   <= err_val;
            end
        end
    end

    // Single-entry write holding register; any abort drops the pending request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (err_set) begin
            req_q <= 1'b0;
        end else if (word_done) begin
            req_q  <= 1'b1;
            addr_q <= LOAD_BASE + word_idx_q;
            data_q <= {byte_hi_q, rx_data};
        end else if (ack_fire) begin
            req_q <= 1'b0;
        end
    end

    assign mem_wr_req   = req_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign boot_done    = (state_q == DONE);
    assign err_code     = err_q;
    assign boot_err     = (err_q != ERR_NONE);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: frame loads, checksum and overrun
// aborts, inter-byte timeout, reset during a pending write and address wrap.
module tb_uart_boot_loader;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        mem_wr_ack = 1'b0;

    logic        mem_wr_req, boot_done, boot_err;
    logic [15:0] mem_addr, mem_data, words_loaded;
    logic [1:0]  err_code;

    logic        w_req, w_done, w_err;
    logic [15:0] w_addr, w_data, w_words;
    logic [1:0]  w_code;

    int tests = 0;
    int fails = 0;
    bit ack_en = 1'b0;
    int req_age = 0;
    bit any_req = 1'b0;
    logic [15:0] la[$], ld[$], wa[$], wd[$];

    uart_boot_loader #(.LOAD_BASE(16'h0000), .TIMEOUT_CYCLES(TO), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wr_ack(mem_wr_ack), .boot_done(boot_done), .boot_err(boot_err),
        .err_code(err_code), .words_loaded(words_loaded)
    );

    uart_boot_loader #(.LOAD_BASE(16'hFFFF), .TIMEOUT_CYCLES(TO), .MAGIC(8'hA5)) dut_w (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_wr_req(w_req), .mem_addr(w_addr), .mem_data(w_data),
        .mem_wr_ack(mem_wr_ack), .boot_done(w_done), .boot_err(w_err),
        .err_code(w_code), .words_loaded(w_words)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: log handshakes completing at this edge, then model the controller,
    // which acks one cycle after it first sees a request.
    task automatic tick();
        bit acc, accw;
        acc  = mem_wr_req && mem_wr_ack;
        accw = w_req && mem_wr_ack;
        if (acc)  begin la.push_back(mem_addr); ld.push_back(mem_data); end
        if (accw) begin wa.push_back(w_addr);   wd.push_back(w_data);   end
        @(posedge clk);
        #1;
        if (mem_wr_req) any_req = 1'b1;
        if (acc || !mem_wr_req) req_age = mem_wr_req ? 1 : 0;
        else                    req_age++;
        mem_wr_ack = ack_en && (req_age >= 2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [63:0] bytes, input int n);
        for (int i = n - 1; i >= 0; i--) send(bytes[i*8 +: 8]);
    endtask

    task automatic clear_logs();
        la.delete(); ld.delete(); wa.delete(); wd.delete();
        any_req = 1'b0;
    endtask

    task automatic do_reset();
        ack_en     = 1'b0;
        mem_wr_ack = 1'b0;
        rx_valid   = 1'b0;
        rst_n      = 1'b0;
        ticks(2);
        rst_n   = 1'b1;
        req_age = 0;
        clear_logs();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !boot_done; i++) tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_req",   mem_wr_req, 1'b0);
        check("rst_addr",  mem_addr, 16'h0000);
        check("rst_data",  mem_data, 16'h0000);
        check("rst_done",  boot_done, 1'b0);
        check("rst_err",   boot_err, 1'b0);
        check("rst_code",  err_code, 2'b00);
        check("rst_words", words_loaded, 16'd0);

        // Good two-word frame
        ack_en = 1'b1;
        send_seq(64'hA5_00_02_12_34_AB_CD_BE, 8);
        wait_done(40);
        check("t1_done",  boot_done, 1'b1);
        check("t1_nwr",   la.size(), 2);
        check("t1_a0",    la.size() > 0 ? la[0] : 16'hxxxx, 16'h0000);
        check("t1_d0",    ld.size() > 0 ? ld[0] : 16'hxxxx, 16'h1234);
        check("t1_a1",    la.size() > 1 ? la[1] : 16'hxxxx, 16'h0001);
        check("t1_d1",    ld.size() > 1 ? ld[1] : 16'hxxxx, 16'hABCD);
        check("t1_words", words_loaded, 16'd2);
        check("t1_code",  err_code, 2'b00);
        // Bytes after DONE are ignored
        clear_logs();
        send_seq(64'hA5_00_01_11_22, 5);
        ticks(4);
        check("t1_sticky",   boot_done, 1'b1);
        check("t1_ign_words", words_loaded, 16'd2);
        check("t1_ign_req",  any_req, 1'b0);

        // Bad checksum, then a good frame
        do_reset();
        ack_en = 1'b1;
        send_seq(64'hA5_00_02_12_34_AB_CD_BF, 8);
        for (int i = 0; i < 40 && !boot_err; i++) tick();
        check("t2_code",  err_code, 2'b01);
        check("t2_err",   boot_err, 1'b1);
        check("t2_done",  boot_done, 1'b0);
        check("t2_nwr",   la.size(), 2);
        check("t2_words", words_loaded, 16'd2);
        ticks(2);
        clear_logs();
        send_seq(64'hA5_00_02_12_34_AB_CD_BE, 8);
        wait_done(40);
        check("t2b_done",  boot_done, 1'b1);
        check("t2b_err",   boot_err, 1'b0);
        check("t2b_code",  err_code, 2'b00);
        check("t2b_nwr",   la.size(), 2);
        check("t2b_words", words_loaded, 16'd2);

        // Leading garbage, empty frame
        do_reset();
        ack_en = 1'b1;
        send_seq(64'h00_FF_5A, 3);
        check("t3_hunt", boot_done, 1'b0);
        send_seq(64'hA5_00_00_00, 4);
        wait_done(20);
        check("t3_done",  boot_done, 1'b1);
        check("t3_nreq",  any_req, 1'b0);
        check("t3_words", words_loaded, 16'd0);

        // Overrun with a stuck controller
        do_reset();
        ack_en = 1'b0;
        send_seq(64'hA5_00_02_12_34, 5);
        check("t4_req1",  mem_wr_req, 1'b1);
        check("t4_addr1", mem_addr, 16'h0000);
        check("t4_data1", mem_data, 16'h1234);
        send(8'hAB);
        check("t4_hold",  mem_wr_req, 1'b1);
        send(8'hCD);
        check("t4_code",  err_code, 2'b10);
        check("t4_err",   boot_err, 1'b1);
        check("t4_drop",  mem_wr_req, 1'b0);
        check("t4_words", words_loaded, 16'd0);
        tick();
        check("t4_done",  boot_done, 1'b0);

        // Inter-byte timeout mid-word
        do_reset();
        ack_en = 1'b1;
        send_seq(64'hA5_00_01_12, 4);
        ticks(TO - 1);
        check("t5_before", err_code, 2'b00);
        tick();
        check("t5_code",  err_code, 2'b11);
        check("t5_err",   boot_err, 1'b1);
        check("t5_noreq", any_req, 1'b0);

        // Reset while a write is pending, then reload with address wrap
        do_reset();
        ack_en = 1'b0;
        send_seq(64'hA5_00_02_12_34, 5);
        check("t6_req", mem_wr_req, 1'b1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_req",   mem_wr_req, 1'b0);
        check("t6_rst_addr",  mem_addr, 16'h0000);
        check("t6_rst_data",  mem_data, 16'h0000);
        check("t6_rst_words", words_loaded, 16'd0);
        check("t6_rst_flags", {boot_done, boot_err, err_code}, 4'b0000);
        check("t6_rst_wreq",  w_req, 1'b0);
        rst_n   = 1'b1;
        req_age = 0;
        clear_logs();
        ack_en  = 1'b1;
        send_seq(64'hA5_00_02_12_34_AB_CD_BE, 8);
        wait_done(40);
        check("t6_done",  boot_done, 1'b1);
        check("t6_wdone", w_done, 1'b1);
        check("t6_wnwr",  wa.size(), 2);
        check("t6_wa0",   wa.size() > 0 ? wa[0] : 16'hxxxx, 16'hFFFF);
        check("t6_wd0",   wd.size() > 0 ? wd[0] : 16'hxxxx, 16'h1234);
        check("t6_wa1",   wa.size() > 1 ? wa[1] : 16'hxxxx, 16'h0000);
        check("t6_wd1",   wd.size() > 1 ? wd[1] : 16'hxxxx, 16'hABCD);
        check("t6_wwords", w_words, 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
